// File: rtl/icache_refill_ahb_if.sv
// AHB-Lite master/slave signal bundle used by the instruction-cache line refill engine.
interface icache_refill_ahb_if #(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned WORD_WIDTH    = 32,
  parameter int unsigned HBURST_WIDTH  = 3,
  parameter int unsigned HPROT_WIDTH   = 4,
  parameter int unsigned HMASTER_WIDTH = 1
);
  logic [ADDR_WIDTH-1:0]    HADDR;
  logic [HBURST_WIDTH-1:0]  HBURST;
  logic                     HMASTLOCK;
  logic [HPROT_WIDTH-1:0]   HPROT;
  logic [2:0]               HSIZE;
  logic                     HNONSEC;
  logic                     HEXCL;
  logic [HMASTER_WIDTH-1:0] HMASTER;
  logic [1:0]               HTRANS;
  logic [WORD_WIDTH-1:0]    HWDATA;
  logic [WORD_WIDTH/8-1:0]  HWSTRB;
  logic                     HWRITE;
  logic [WORD_WIDTH-1:0]    HRDATA;
  logic                     HREADY;
  logic                     HRESP;

  modport master (
    output HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HNONSEC, HEXCL, HMASTER,
           HTRANS, HWDATA, HWSTRB, HWRITE,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HNONSEC, HEXCL, HMASTER,
           HTRANS, HWDATA, HWSTRB, HWRITE,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/icache_refill_ahb.sv
// Instruction-cache line refill: fetches one aligned 8-word line as an AHB-Lite
// INCR8 read burst and hands the assembled line back in a single cycle.
module icache_refill_ahb #(
  parameter int unsigned ADDR_WIDTH             = 32,
  parameter int unsigned WORD_WIDTH             = 32,
  parameter int unsigned BLOCK_WIDTH            = 256,
  parameter int unsigned BLOCK_WIDTH_WORDS      = 8,
  parameter int unsigned LOG2_BLOCK_WIDTH_WORDS = 3,
  parameter int unsigned HBURST_WIDTH           = 3,
  parameter int unsigned HPROT_WIDTH            = 4,
  parameter int unsigned HMASTER_WIDTH          = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   refill_req,
  input  logic [ADDR_WIDTH-1:0]  refill_addr,
  output logic                   refill_ready,
  output logic                   refill_done,
  output logic                   refill_err,
  output logic [BLOCK_WIDTH-1:0] refill_data,
  icache_refill_ahb_if.master    ahb
);
  localparam int unsigned CNT_WIDTH = LOG2_BLOCK_WIDTH_WORDS + 1;
  localparam logic [CNT_WIDTH-1:0]  BEATS     = CNT_WIDTH'(BLOCK_WIDTH_WORDS);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(BLOCK_WIDTH / 8 - 1);
  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_ERR, ST_DONE} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  base_q, base_d;
  logic [CNT_WIDTH-1:0]   addr_cnt_q, addr_cnt_d;
  logic [CNT_WIDTH-1:0]   data_cnt_q, data_cnt_d;
  logic                   data_pending_q, data_pending_d;
  logic                   err_q, err_d;
  logic [BLOCK_WIDTH-1:0] data_q, data_d;
  logic                   addr_phase;

  // Next-state: accept a miss, run address/data pipeline, handle two-cycle ERROR.
  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    addr_cnt_d     = addr_cnt_q;
    data_cnt_d     = data_cnt_q;
    data_pending_d = data_pending_q;
    err_d          = err_q;
    data_d         = data_q;
    addr_phase     = (state_q == ST_BURST) && (addr_cnt_q < BEATS);

    case (state_q)
      ST_IDLE: begin
        if (refill_req) begin
          base_d         = refill_addr & ~LINE_MASK;
          addr_cnt_d     = '0;
          data_cnt_d     = '0;
          data_pending_d = 1'b0;
          err_d          = 1'b0;
          state_d        = ST_BURST;
        end
      end
      ST_BURST: begin
        if (ahb.HRESP && !ahb.HREADY) begin
          // First ERROR cycle: drop the rest of the burst from the next cycle on.
          err_d          = 1'b1;
          data_pending_d = 1'b0;
          state_d        = ST_ERR;
        end else if (ahb.HREADY) begin
          if (addr_phase) begin
            addr_cnt_d     = addr_cnt_q + 1'b1;
            data_pending_d = 1'b1;
          end else begin
            data_pending_d = 1'b0;
          end
          if (data_pending_q) begin
            for (int unsigned i = 0; i < BLOCK_WIDTH_WORDS; i++) begin
              if (data_cnt_q == CNT_WIDTH'(i)) begin
                data_d[i*WORD_WIDTH +: WORD_WIDTH] = ahb.HRDATA;
              end
            end
            data_cnt_d = data_cnt_q + 1'b1;
            if (data_cnt_d == BEATS) begin
              state_d = ST_DONE;
            end
          end
        end
      end
      ST_ERR: begin
        if (ahb.HREADY) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      base_q         <= '0;
      addr_cnt_q     <= '0;
      data_cnt_q     <= '0;
      data_pending_q <= 1'b0;
      err_q          <= 1'b0;
      data_q         <= '0;
    end else begin
      state_q        <= state_d;
      base_q         <= base_d;
      addr_cnt_q     <= addr_cnt_d;
      data_cnt_q     <= data_cnt_d;
      data_pending_q <= data_pending_d;
      err_q          <= err_d;
      data_q         <= data_d;
    end
  end

  // Outputs decoded from registered state only; bus controls tied per read-only master.
  always_comb begin
    refill_ready  = (state_q == ST_IDLE);
    refill_done   = (state_q == ST_DONE);
    refill_err    = (state_q == ST_DONE) && err_q;
    refill_data   = data_q;
    ahb.HADDR     = base_q + ADDR_WIDTH'({addr_cnt_q, 2'b00});
    ahb.HTRANS    = !addr_phase ? TRANS_IDLE
                  : ((addr_cnt_q == '0) ? TRANS_NONSEQ : TRANS_SEQ);
    ahb.HBURST    = HBURST_WIDTH'(3'b101);
    ahb.HMASTLOCK = 1'b0;
    ahb.HPROT     = HPROT_WIDTH'(4'b0010);
    ahb.HSIZE     = 3'b010;
    ahb.HNONSEC   = 1'b0;
    ahb.HEXCL     = 1'b0;
    ahb.HMASTER   = '0;
    ahb.HWDATA    = '0;
    ahb.HWSTRB    = '0;
    ahb.HWRITE    = 1'b0;
  end
endmodule

// File: tb/tb_icache_refill_ahb.sv
// Bench for icache_refill_ahb: a transaction-level AHB slave plus line model drives
// random and directed refills and predicts every bus cycle and the returned line.
module tb_icache_refill_ahb;
  logic         clk = 1'b0;
  logic         rst;
  logic         refill_req;
  logic [31:0]  refill_addr;
  logic         refill_ready;
  logic         refill_done;
  logic         refill_err;
  logic [255:0] refill_data;

  icache_refill_ahb_if #(
    .ADDR_WIDTH(32), .WORD_WIDTH(32), .HBURST_WIDTH(3), .HPROT_WIDTH(4), .HMASTER_WIDTH(1)
  ) ahb ();

  icache_refill_ahb #(
    .ADDR_WIDTH(32), .WORD_WIDTH(32), .BLOCK_WIDTH(256), .BLOCK_WIDTH_WORDS(8),
    .LOG2_BLOCK_WIDTH_WORDS(3), .HBURST_WIDTH(3), .HPROT_WIDTH(4), .HMASTER_WIDTH(1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .refill_req   (refill_req),
    .refill_addr  (refill_addr),
    .refill_ready (refill_ready),
    .refill_done  (refill_done),
    .refill_err   (refill_err),
    .refill_data  (refill_data),
    .ahb          (ahb.master)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive requests for the next cycle
  bit          drv_req = 1'b0;
  bit          drv_rst = 1'b0;
  logic [31:0] drv_addr = '0;

  // Configuration of the next accepted line
  bit cfg_pattern = 1'b0;
  int cfg_wait[8];
  int cfg_err_beat = 8;

  // Transaction-level model
  bit           m_busy = 1'b0;
  bit           m_done_now = 1'b0;
  bit           m_done_next = 1'b0;
  bit           m_cancel = 1'b0;
  bit           m_dp = 1'b0;
  bit           m_err_stage = 1'b0;
  bit           m_err_txn = 1'b0;
  int           m_addr_beat = 0;
  int           m_dp_beat = 0;
  int           m_err_beat = 8;
  int           m_captured = 0;
  int           m_waits = 0;
  int           m_t0 = 0;
  int           cyc = 0;
  logic [31:0]  m_base = '0;
  logic [31:0]  m_words[8];
  int           m_wait[8];
  logic [255:0] m_line = '0;

  task automatic cycle();
    bit           exp_aphase;
    bit           hready;
    bit           hresp;
    logic [31:0]  hrdata;
    bit           accept;
    logic [255:0] mask;
    @(negedge clk);
    cyc++;
    check_eq("refill_ready", refill_ready, !m_busy);
    check_eq("refill_done", refill_done, m_done_now);
    if (m_done_now) begin
      check_eq("refill_err", refill_err, m_err_txn);
      mask = '0;
      for (int i = 0; i < m_captured; i++) mask[i*32 +: 32] = '1;
      check_eq("refill_data", refill_data & mask, m_line & mask);
      if (!m_err_txn) check_eq("latency", cyc - m_t0, 10 + m_waits);
    end else begin
      check_eq("refill_err_idle", refill_err, 1'b0);
    end

    exp_aphase = m_busy && !m_done_now && !m_cancel && (m_addr_beat < 8);
    if (exp_aphase) begin
      check_eq("HTRANS", ahb.HTRANS, (m_addr_beat == 0) ? 2'b10 : 2'b11);
      check_eq("HADDR", ahb.HADDR, m_base + 32'(4 * m_addr_beat));
    end else begin
      check_eq("HTRANS_idle", ahb.HTRANS, 2'b00);
    end

    // Slave response for this cycle
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = $urandom;
    if (m_dp) begin
      if (m_wait[m_dp_beat] > 0) begin
        hready = 1'b0;
        m_wait[m_dp_beat]--;
        m_waits++;
      end else if (m_dp_beat == m_err_beat) begin
        hresp = 1'b1;
        if (!m_err_stage) begin
          hready      = 1'b0;
          m_err_stage = 1'b1;
          m_cancel    = 1'b1;
        end else begin
          m_done_next = 1'b1;
        end
      end else begin
        hrdata = m_words[m_dp_beat];
        m_line[m_dp_beat*32 +: 32] = hrdata;
        m_captured = m_dp_beat + 1;
        if (m_dp_beat == 7) m_done_next = 1'b1;
      end
    end
    if (hready) begin
      if (exp_aphase) begin
        m_dp = 1'b1;
        m_dp_beat = m_addr_beat;
        m_addr_beat++;
      end else begin
        m_dp = 1'b0;
      end
    end

    ahb.HREADY  = hready;
    ahb.HRESP   = hresp;
    ahb.HRDATA  = hrdata;
    rst         = drv_rst;
    refill_req  = drv_req;
    refill_addr = drv_addr;

    accept = drv_req && !m_busy && !drv_rst;
    if (m_done_now) m_busy = 1'b0;
    m_done_now  = m_done_next;
    m_done_next = 1'b0;
    if (accept) begin
      m_busy      = 1'b1;
      m_t0        = cyc;
      m_base      = drv_addr & ~32'h1f;
      m_addr_beat = 0;
      m_dp        = 1'b0;
      m_cancel    = 1'b0;
      m_err_stage = 1'b0;
      m_err_beat  = cfg_err_beat;
      m_err_txn   = (cfg_err_beat < 8);
      m_captured  = 0;
      m_waits     = 0;
      m_line      = '0;
      for (int i = 0; i < 8; i++) begin
        m_words[i] = cfg_pattern ? 32'hA0 + 32'(i) : $urandom;
        m_wait[i]  = cfg_wait[i];
      end
    end
    if (drv_rst) begin
      m_busy     = 1'b0;
      m_dp       = 1'b0;
      m_done_now = 1'b0;
    end
  endtask

  // Issue one request, then run until the model returns to idle.
  // busy_at / rst_at are offsets from T1 (negative = not used).
  task automatic do_txn(input logic [31:0] addr, input int busy_at, input int rst_at);
    int guard;
    int rel;
    drv_req  = 1'b1;
    drv_addr = addr;
    guard    = 0;
    while (!m_busy && guard < 20) begin
      cycle();
      guard++;
    end
    if (!m_busy) check_eq("timeout_accept", 1'b1, 1'b0);
    drv_req = 1'b0;
    rel = 0;
    while (m_busy && rel < 200) begin
      drv_req  = (busy_at >= 0) && (rel >= busy_at) && (rel < busy_at + 3);
      drv_addr = 32'h2000;
      drv_rst  = (rel == rst_at);
      cycle();
      rel++;
    end
    if (m_busy) check_eq("timeout_done", 1'b1, 1'b0);
    drv_req = 1'b0;
    drv_rst = 1'b0;
  endtask

  task automatic cfg_clear();
    for (int i = 0; i < 8; i++) cfg_wait[i] = 0;
    cfg_err_beat = 8;
  endtask

  initial begin
    rst = 1'b1;
    refill_req = 1'b0;
    refill_addr = '0;
    ahb.HREADY = 1'b1;
    ahb.HRESP = 1'b0;
    ahb.HRDATA = '0;
    cfg_clear();
    repeat (3) @(negedge clk);
    check_eq("rst_HTRANS", ahb.HTRANS, 2'b00);
    check_eq("rst_HADDR", ahb.HADDR, 32'h0);
    check_eq("rst_ready", refill_ready, 1'b1);
    check_eq("rst_done", refill_done, 1'b0);
    check_eq("rst_err", refill_err, 1'b0);
    check_eq("rst_data", refill_data, 256'h0);
    check_eq("HBURST", ahb.HBURST, 3'b101);
    check_eq("HPROT", ahb.HPROT, 4'b0010);
    check_eq("HSIZE", ahb.HSIZE, 3'b010);
    check_eq("HWRITE", ahb.HWRITE, 1'b0);
    check_eq("HMASTLOCK", {ahb.HMASTLOCK, ahb.HNONSEC, ahb.HEXCL, ahb.HMASTER}, 4'b0000);
    check_eq("HWDATA", {ahb.HWDATA, ahb.HWSTRB}, 36'h0);

    // Zero-wait fill with a recognisable pattern
    cfg_pattern = 1'b1;
    do_txn(32'h0000_1234, -1, -1);
    // Two wait states on beat 3's data phase
    cfg_wait[3] = 2;
    do_txn(32'h0000_1234, -1, -1);
    cfg_clear();
    // ERROR on beat 4
    cfg_err_beat = 4;
    do_txn(32'h0000_1234, -1, -1);
    cfg_clear();
    // Request while busy (from T3) must be ignored
    do_txn(32'h0000_1234, 2, -1);
    // Reset at T5, then a normal refill at 0x40
    do_txn(32'h0000_1234, -1, 4);
    do_txn(32'h0000_0040, -1, -1);
    // Back-to-back random lines
    cfg_pattern = 1'b0;
    do_txn($urandom, -1, -1);
    do_txn($urandom, -1, -1);

    // Random mix of waits, errors, busy requests and occasional reset
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 8; i++)
        cfg_wait[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      cfg_err_beat = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : 8;
      do_txn($urandom,
             ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 6)) : -1,
             ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 8)) : -1);
      if ($urandom_range(0, 2) == 0) cycle();
    end
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
